// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit 7-segment scan scheduler with dead-time blanking, per-digit blink
// and a brightness duty window; define SEG_SCAN_BRIGHTNESS_EN to honour the bright input.
module seg_scan_ctrl #(
   parameter int SLOT_CYCLES  = 2048,
   parameter int BLANK_CYCLES = 64,
   parameter int BLINK_FRAMES = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] digit_code,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  digit_en,
   input  logic [3:0]  blink_en,
   input  logic [2:0]  bright,
   output logic [6:0]  segment,
   output logic        dp_out,
   output logic [3:0]  digit_sel,
   output logic        frame_start
);
   localparam int SW = $clog2(SLOT_CYCLES);
   localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [1:0] S_BLANK = 2'd0, S_ON = 2'd1, S_OFF = 2'd2;
   localparam logic [34:0] ACTIVE = 35'(SLOT_CYCLES - BLANK_CYCLES);
   localparam logic [34:0] BLANK = 35'(BLANK_CYCLES);
   localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [SW-1:0] slot_q, slot_d;
   logic [1:0]    dig_q, dig_d;
   logic [FW-1:0] frm_q, frm_d;
   logic          ph_q, ph_d;
   logic [1:0]    st_q, st_d;
   logic [15:0]   sh_code_q, sh_code_d;
   logic [3:0]    sh_dp_q, sh_dp_d, sh_en_q, sh_en_d, sh_blk_q, sh_blk_d;
   logic [6:0]    seg_q, seg_d;
   logic          dpo_q, dpo_d, fs_q, fs_d;
   logic [3:0]    sel_q, sel_d;
   logic          slot_wrap, dig_wrap, frm_wrap, drive;
   logic [34:0]   on_len;
`ifdef SEG_SCAN_BRIGHTNESS_EN
   logic [2:0] sh_br_q, sh_br_d;
   // brightness is shadowed with the other attributes and sets the on window in eighths
   always_comb begin
      sh_br_d = fs_q ? bright : sh_br_q;
      on_len = (ACTIVE * 35'({1'b0, sh_br_d} + 4'd1)) >> 3;
   end
   // brightness shadow register
   always_ff @(posedge clock or posedge reset)
      if (reset) sh_br_q <= '0;
      else sh_br_q <= sh_br_d;
`else
   logic unused_bright;
   assign unused_bright = ^bright;
   assign on_len = ACTIVE;
`endif
   // counters hold the scan position whose outputs are registered on the next edge;
   // the shadow mux output is used so a capture takes effect within the same frame
   always_comb begin
      slot_wrap = slot_q == SW'(SLOT_CYCLES - 1);
      dig_wrap = slot_wrap && dig_q == 2'd3;
      frm_wrap = dig_wrap && frm_q == FW'(BLINK_FRAMES - 1);
      slot_d = slot_wrap ? '0 : slot_q + SW'(1);
      dig_d = slot_wrap ? dig_q + 2'd1 : dig_q;
      frm_d = frm_wrap ? '0 : dig_wrap ? frm_q + FW'(1) : frm_q;
      ph_d = ph_q ^ frm_wrap;
      st_d = 35'(slot_d) < BLANK ? S_BLANK : 35'(slot_d) < BLANK + on_len ? S_ON : S_OFF;
      sh_code_d = fs_q ? digit_code : sh_code_q;
      sh_dp_d = fs_q ? dp_in : sh_dp_q;
      sh_en_d = fs_q ? digit_en : sh_en_q;
      sh_blk_d = fs_q ? blink_en : sh_blk_q;
      drive = st_q == S_ON && sh_en_d[dig_q] && !(sh_blk_d[dig_q] && ph_q);
      fs_d = slot_q == '0 && dig_q == 2'd0;
      sel_d = drive ? 4'b0001 << dig_q : 4'b0000;
      seg_d = drive ? SEG[sh_code_d[{dig_q, 2'b00} +: 4]] : 7'd0;
      dpo_d = drive && sh_dp_d[dig_q];
   end
   // scan state, shadow registers and registered outputs
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         slot_q <= '0;
         dig_q <= '0;
         frm_q <= '0;
         ph_q <= 1'b0;
         st_q <= S_BLANK;
         sh_code_q <= '0;
         sh_dp_q <= '0;
         sh_en_q <= '0;
         sh_blk_q <= '0;
         seg_q <= '0;
         dpo_q <= 1'b0;
         sel_q <= '0;
         fs_q <= 1'b0;
      end else begin
         slot_q <= slot_d;
         dig_q <= dig_d;
         frm_q <= frm_d;
         ph_q <= ph_d;
         st_q <= st_d;
         sh_code_q <= sh_code_d;
         sh_dp_q <= sh_dp_d;
         sh_en_q <= sh_en_d;
         sh_blk_q <= sh_blk_d;
         seg_q <= seg_d;
         dpo_q <= dpo_d;
         sel_q <= sel_d;
         fs_q <= fs_d;
      end
   assign segment = seg_q;
   assign dp_out = dpo_q;
   assign digit_sel = sel_q;
   assign frame_start = fs_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with 16-cycle slots, 2-cycle blank, 2-frame blink
module tb_seg_scan_ctrl;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] digit_code = '0;
   logic [3:0]  dp_in = '0, digit_en = '0, blink_en = '0;
   logic [2:0]  bright = '0;
   logic [6:0]  segment;
   logic        dp_out, frame_start;
   logic [3:0]  digit_sel;
   int total = 0, passed = 0;
   logic [3:0] sel_a [64];
   logic [6:0] seg_a [64];
   logic       dp_a [64], fs_a [64];
`ifdef SEG_SCAN_BRIGHTNESS_EN
   localparam int ON0 = 1, ON3 = 7;
`else
   localparam int ON0 = 14, ON3 = 14;
`endif

   always #5 clock = ~clock;

   seg_scan_ctrl #(.SLOT_CYCLES(16), .BLANK_CYCLES(2), .BLINK_FRAMES(2)) dut (
      .clock(clock), .reset(reset), .digit_code(digit_code), .dp_in(dp_in),
      .digit_en(digit_en), .blink_en(blink_en), .bright(bright), .segment(segment),
      .dp_out(dp_out), .digit_sel(digit_sel), .frame_start(frame_start));

   task step;
      @(posedge clock);
      @(negedge clock);
   endtask

   // records n cycles starting now (index 0); optionally changes digit_code at index chg_at
   task grab(input int n, input int chg_at, input logic [15:0] chg_val);
      for (int i = 0; i < n; i++) begin
         if (i == chg_at) digit_code = chg_val;
         sel_a[i] = digit_sel;
         seg_a[i] = segment;
         dp_a[i] = dp_out;
         fs_a[i] = frame_start;
         step();
      end
   endtask

   function automatic int count_sel(input logic [3:0] v, input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++) if (sel_a[i] == v) n++;
      return n;
   endfunction

   function automatic int count_on(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++) if (sel_a[i] != 4'b0000) n++;
      return n;
   endfunction

   task test_reset;
      logic bad;
      int n;
      digit_code = 16'h1234; digit_en = 4'hF; bright = 3'd7; blink_en = 4'h0; dp_in = 4'h0;
      reset = 1'b1;
      bad = 1'b0;
      repeat (3) begin
         step();
         if (segment !== 7'd0 || dp_out !== 1'b0 || digit_sel !== 4'd0 || frame_start !== 1'b0) bad = 1'b1;
      end
      total++; if (bad !== 1'b0) $display("FAIL reset_outputs: got nonzero output during reset, required all 0"); else passed++;
      reset = 1'b0;
      step();
      total++; if (frame_start !== 1'b1) $display("FAIL first_frame_start: got %b required 1", frame_start); else passed++;
      grab(64, -1, '0);
      n = 0;
      for (int i = 0; i < 64; i++) if (fs_a[i]) n++;
      total++; if (n !== 1) $display("FAIL frame_start_count: got %0d required 1", n); else passed++;
      total++; if (frame_start !== 1'b1) $display("FAIL frame_period: got %b at cycle 64 required 1", frame_start); else passed++;
   endtask

   task test_digits;
      int n;
      grab(64, -1, '0);
      n = 0;
      for (int i = 0; i < 16; i++) if (sel_a[i] == 4'b0001 && seg_a[i] == 7'h66) n++;
      total++; if (n !== 14) $display("FAIL dig0_on_cycles: got %0d required 14", n); else passed++;
      total++; if (sel_a[1] !== 4'b0000) $display("FAIL dig0_blank: got %b required 0000", sel_a[1]); else passed++;
      total++; if (sel_a[2] !== 4'b0001) $display("FAIL dig0_first_on: got %b required 0001", sel_a[2]); else passed++;
      total++; if (seg_a[18] !== 7'h4F) $display("FAIL dig1_seg: got %h required 4f", seg_a[18]); else passed++;
      total++; if (seg_a[34] !== 7'h5B) $display("FAIL dig2_seg: got %h required 5b", seg_a[34]); else passed++;
      n = 0;
      for (int i = 48; i < 64; i++) if (sel_a[i] == 4'b1000 && seg_a[i] == 7'h06) n++;
      total++; if (n !== 14) $display("FAIL dig3_on_cycles: got %0d required 14", n); else passed++;
   endtask

   task test_bright;
      bright = 3'd0;
      grab(64, -1, '0);
      total++; if (count_on(0, 63) !== 4 * ON0) $display("FAIL bright0_on_total: got %0d required %0d", count_on(0, 63), 4 * ON0); else passed++;
      total++; if (sel_a[1 + ON0] !== 4'b0001) $display("FAIL bright0_last_on: got %b required 0001", sel_a[1 + ON0]); else passed++;
      total++; if (sel_a[2 + ON0] !== 4'b0000) $display("FAIL bright0_off: got %b required 0000", sel_a[2 + ON0]); else passed++;
      bright = 3'd3;
      grab(64, -1, '0);
      total++; if (count_on(0, 63) !== 4 * ON3) $display("FAIL bright3_on_total: got %0d required %0d", count_on(0, 63), 4 * ON3); else passed++;
      total++; if (sel_a[1 + ON3] !== 4'b0001) $display("FAIL bright3_last_on: got %b required 0001", sel_a[1 + ON3]); else passed++;
      total++; if (sel_a[15] !== (ON3 == 14 ? 4'b0001 : 4'b0000)) $display("FAIL bright3_slot_end: got %b", sel_a[15]); else passed++;
      bright = 3'd7;
   endtask

   task test_enable;
      int n;
      digit_en = 4'b0101; dp_in = 4'b0001;
      grab(64, -1, '0);
      total++; if (count_on(0, 63) !== 28) $display("FAIL en_on_total: got %0d required 28", count_on(0, 63)); else passed++;
      n = count_on(16, 31) + count_on(48, 63);
      total++; if (n !== 0) $display("FAIL en_disabled_dark: got %0d cycles required 0", n); else passed++;
      n = 0;
      for (int i = 0; i < 64; i++) if (dp_a[i] && sel_a[i] == 4'b0001) n++;
      for (int i = 0; i < 64; i++) if (dp_a[i] && sel_a[i] != 4'b0001) n += 100;
      total++; if (n !== 14) $display("FAIL dp_window: got %0d required 14", n); else passed++;
      total++; if (frame_start !== 1'b1) $display("FAIL en_frame_period: got %b required 1", frame_start); else passed++;
      digit_en = 4'hF; dp_in = 4'h0;
   endtask

   task test_blink;
      int exp_b [5] = '{14, 14, 0, 0, 14};
      blink_en = 4'b0010;
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      step();
      for (int f = 0; f < 5; f++) begin
         grab(64, -1, '0);
         total++; if (count_sel(4'b0010, 16, 31) !== exp_b[f]) $display("FAIL blink_frame%0d: got %0d required %0d", f, count_sel(4'b0010, 16, 31), exp_b[f]); else passed++;
         if (f == 2) begin
            total++; if (count_sel(4'b0001, 0, 15) !== 14) $display("FAIL blink_other_digit: got %0d required 14", count_sel(4'b0001, 0, 15)); else passed++;
         end
      end
      blink_en = 4'h0;
   endtask

   task test_shadow_reset;
      grab(64, 24, 16'hABCD);
      total++; if (seg_a[34] !== 7'h5B) $display("FAIL shadow_old_dig2: got %h required 5b", seg_a[34]); else passed++;
      total++; if (sel_a[50] !== 4'b1000 || seg_a[50] !== 7'h06) $display("FAIL shadow_old_dig3: got %b/%h required 1000/06", sel_a[50], seg_a[50]); else passed++;
      grab(40, -1, '0);
      total++; if (seg_a[2] !== 7'h5E) $display("FAIL shadow_new_dig0: got %h required 5e", seg_a[2]); else passed++;
      total++; if (digit_sel !== 4'b0100 || segment !== 7'h7C) $display("FAIL new_dig2: got %b/%h required 0100/7c", digit_sel, segment); else passed++;
      reset = 1'b1;
      #1;
      total++; if (digit_sel !== 4'b0000 || segment !== 7'd0 || dp_out !== 1'b0) $display("FAIL async_reset: got %b/%h/%b required 0", digit_sel, segment, dp_out); else passed++;
      @(negedge clock);
      step();
      reset = 1'b0;
      step();
      total++; if (frame_start !== 1'b1) $display("FAIL restart_frame_start: got %b required 1", frame_start); else passed++;
      step(); step();
      total++; if (digit_sel !== 4'b0001 || segment !== 7'h5E) $display("FAIL restart_dig0: got %b/%h required 0001/5e", digit_sel, segment); else passed++;
   endtask

   initial begin
      test_reset();
      test_digits();
      test_bright();
      test_enable();
      test_blink();
      test_shadow_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
